// File: rtl/list_pkg.sv
// ---------------------------------------------------------------------------
// list_pkg
//   Shared definitions for the linked-list builder and the sum traverser.
//   A node occupies NODE_WORDS consecutive words: the value at VAL_OFS and
//   the next pointer at NEXT_OFS. A next pointer equal to NULL_PTR ends the
//   list.
// ---------------------------------------------------------------------------
package list_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCEPT  = 3'd1,
    ST_WR_VAL  = 3'd2,
    ST_WR_NEXT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int NODE_WORDS = 2;
  localparam int VAL_OFS    = 0;
  localparam int NEXT_OFS   = 1;
  localparam int NULL_PTR   = 0;

endpackage

// File: rtl/node_alloc.sv
// ---------------------------------------------------------------------------
// node_alloc
//   Node slot allocator for the list builder. Owns the address of the node
//   currently being written and the count of nodes completed this session.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   init        restart allocation at BASE_ADDR with a zero count
//   advance     current node finished: step to the next slot
//   cur_addr    address of the current node's value word
//   next_addr   address of the following node (cur_addr + NODE_WORDS)
//   node_cnt    nodes completed in this session
//   last_slot   current node is the final one that fits (MAX_NODES-1 done)
// ---------------------------------------------------------------------------
module node_alloc
  import list_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int MAX_NODES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              advance,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [ADDR_W-1:0] next_addr,
  output logic [ADDR_W-1:0] node_cnt,
  output logic              last_slot
);

  // Modulo 2^ADDR_W; the parameter constraints keep this from wrapping.
  assign next_addr = cur_addr + ADDR_W'(NODE_WORDS);
  assign last_slot = (node_cnt == ADDR_W'(MAX_NODES - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr <= ADDR_W'(BASE_ADDR);
      node_cnt <= '0;
    end else if (init) begin
      cur_addr <= ADDR_W'(BASE_ADDR);
      node_cnt <= '0;
    end else if (advance) begin
      cur_addr <= next_addr;
      node_cnt <= node_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/list_builder.sv
// ---------------------------------------------------------------------------
// list_builder
//   Accepts a stream of values over a valid/ready handshake and writes them
//   into word-addressed memory as a singly linked list of {value, next}
//   nodes starting at BASE_ADDR. The list is terminated by a next pointer of
//   0, either on an element flagged in_last or when MAX_NODES is reached
//   (the latter also raises overflow). Each element costs three cycles:
//   accept, value write, pointer write.
//
// Optional build macro: LIST_BUILDER_CHECKSUM_EN adds a running sum of the
//   stored values (modulo 2^DATA_W) on the checksum output.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       level; high = session active, low = abort to idle
//   in_valid    input element valid
//   in_data     element value
//   in_last     element is the final list node
//   in_ready    builder can accept an element this cycle
//   mem_we      memory write strobe
//   mem_addr    memory write address
//   mem_wdata   memory write data
//   head_addr   list head address (BASE_ADDR) for the traverser
//   node_cnt    nodes written in the current session
//   overflow    list truncated at MAX_NODES
//   done        list fully written and terminated
//   checksum    sum of stored values (LIST_BUILDER_CHECKSUM_EN only)
// ---------------------------------------------------------------------------
module list_builder
  import list_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int MAX_NODES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] head_addr,
  output logic [ADDR_W-1:0] node_cnt,
  output logic              overflow,
`ifdef LIST_BUILDER_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic              done
);

  state_t            state_q, state_d;
  logic              last_q;
  logic              init, advance, term;
  logic [ADDR_W-1:0] cur_addr, next_addr;
  logic              last_slot;

  assign head_addr = ADDR_W'(BASE_ADDR);

  node_alloc #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .MAX_NODES (MAX_NODES)
  ) u_alloc (
    .clk       (clk),
    .rst_n     (rst_n),
    .init      (init),
    .advance   (advance),
    .cur_addr  (cur_addr),
    .next_addr (next_addr),
    .node_cnt  (node_cnt),
    .last_slot (last_slot)
  );

  // The current node closes the list on an explicit last element or when it
  // occupies the final slot.
  assign term    = last_q || last_slot;
  assign init    = (state_q == ST_IDLE) && start;
  assign advance = (state_q == ST_WR_NEXT) && start;

  // Strobes are decoded from the registered state only, so an asynchronous
  // reset clears them immediately.
  assign in_ready = (state_q == ST_ACCEPT);
  assign mem_we   = (state_q == ST_WR_VAL) || (state_q == ST_WR_NEXT);
  assign done     = (state_q == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d takes a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (!start) begin
      // Abort wins over every other transition.
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:    state_d = ST_ACCEPT;
        ST_ACCEPT:  if (in_valid) state_d = ST_WR_VAL;
        ST_WR_VAL:  state_d = ST_WR_NEXT;
        ST_WR_NEXT: state_d = term ? ST_DONE : ST_ACCEPT;
        ST_DONE:    state_d = ST_DONE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Write address/data are loaded one cycle ahead of the strobe so they are
  // registered outputs aligned with mem_we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      last_q    <= 1'b0;
      overflow  <= 1'b0;
    end else if (start) begin
      unique case (state_q)
        ST_IDLE: begin
          overflow <= 1'b0;
        end
        ST_ACCEPT: begin
          if (in_valid) begin
            last_q    <= in_last;
            mem_addr  <= cur_addr + ADDR_W'(VAL_OFS);
            mem_wdata <= in_data;
          end
        end
        ST_WR_VAL: begin
          mem_addr  <= cur_addr + ADDR_W'(NEXT_OFS);
          mem_wdata <= term ? DATA_W'(NULL_PTR) : DATA_W'(next_addr);
        end
        ST_WR_NEXT: begin
          if (last_slot && !last_q) overflow <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef LIST_BUILDER_CHECKSUM_EN
  // mem_wdata holds the node value throughout WR_VAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     checksum <= '0;
    else if (init)                  checksum <= '0;
    else if (state_q == ST_WR_VAL)  checksum <= checksum + mem_wdata;
  end
`endif

endmodule

// File: doc/list_builder.md
Name: list_builder

Overview:
- Writer counterpart to the linked-list sum traverser.
- Accepts a stream of data values over a valid/ready handshake and writes them into the shared word-addressed memory as a singly linked list.
- The traverser consumes that list unchanged: node = {value, next pointer}, and a next pointer of 0 terminates the list.
- Sits between the stimulus/host side and the memory port, ahead of the sum controller and datapath.

Parameters:
- DATA_W, 8, memory word width; also the width of stored value and next pointer.
- ADDR_W, 8, memory address width; must satisfy ADDR_W <= DATA_W.
- BASE_ADDR, 0, address of the head node's value word.
- MAX_NODES, 16, list capacity; must satisfy BASE_ADDR + 2*MAX_NODES <= 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; high = build session active, low = abort/return to idle.
- in_valid  in  1  input element valid.
- in_data  in  DATA_W  element value.
- in_last  in  1  element is the final list node.
- in_ready  out  1  builder can accept an element this cycle.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory write address.
- mem_wdata  out  DATA_W  memory write data.
- head_addr  out  ADDR_W  list head address (constant BASE_ADDR), for the traverser.
- node_cnt  out  ADDR_W  nodes written in the current session.
- overflow  out  1  list truncated at MAX_NODES.
- done  out  1  list fully written and terminated.

Behaviour:
- Reset (rst_n low, async): state IDLE. in_ready, mem_we, done, overflow = 0; mem_addr, mem_wdata, node_cnt = 0; internal cur_addr = BASE_ADDR.
- States: IDLE, ACCEPT, WR_VAL, WR_NEXT, DONE. Moore outputs are decoded from registered state. Data and address are registers.
- IDLE:
  - All strobes 0.
  - start=1 -> ACCEPT; cur_addr <= BASE_ADDR, node_cnt <= 0, overflow <= 0.
- ACCEPT:
  - in_ready=1.
  - Handshake occurs when in_valid && in_ready: capture in_data and in_last, -> WR_VAL.
  - No handshake: stay.
- WR_VAL (1 cycle):
  - mem_we=1, mem_addr=cur_addr, mem_wdata=captured value.
  - -> WR_NEXT.
- WR_NEXT (1 cycle):
  - mem_we=1, mem_addr=cur_addr+1.
  - mem_wdata = 0 if last or node_cnt+1 == MAX_NODES; otherwise cur_addr+2, zero-extended to DATA_W.
  - cur_addr <= cur_addr+2; node_cnt <= node_cnt+1.
  - If terminated by capacity without last: overflow <= 1.
  - Terminated (either cause) -> DONE; else -> ACCEPT.
- DONE:
  - done=1, held until start drops.
  - start=0 -> IDLE, clearing done. overflow holds until the next session start.
- Latency and throughput:
  - Handshake to value write: 1 cycle; to pointer write: 2 cycles.
  - Peak acceptance: one element per 3 cycles.
- start=0 in any state -> IDLE next cycle; any in-flight write is dropped and the partial list is not terminated. This abort rule takes priority over all other transitions.
- A single element with in_last=1 produces a 1-node list with next=0.
- Address arithmetic is modulo 2^ADDR_W. The parameter constraint guarantees no wrap; a next pointer of 0 is never produced except as the terminator.

Optional Feature:
- Macro: LIST_BUILDER_CHECKSUM_EN.
- Defined:
  - Adds output checksum [DATA_W-1:0], reset 0, cleared on session start.
  - checksum <= checksum + value in WR_VAL, modulo 2^DATA_W.
  - Final value equals the traverser's expected sum, for end-to-end self-check.
- Undefined: no checksum port or logic.

Decomposition:
- Package list_pkg holds:
  - builder state enum (logic [2:0]);
  - NODE_WORDS=2, VAL_OFS=0, NEXT_OFS=1, NULL_PTR=0, shared with the traverser datapath.
- One natural sub-module, node_alloc: owns cur_addr and node_cnt, with inputs init/advance and outputs cur_addr, next_addr, last_slot.

Test Plan:
- Build [5,3,9], in_last on 9, BASE_ADDR=0 -> writes (0:5)(1:2)(2:3)(3:4)(4:9)(5:0); done=1; node_cnt=3; overflow=0; checksum=17 if enabled.
- Single element 0xAA with in_last -> writes (0:AA)(1:0); done after 2 write cycles.
- MAX_NODES=2, stream 1,2,3 with no in_last -> writes (0:1)(1:2)(2:2)(3:0); overflow=1; in_ready=0 after the 2nd node; element 3 is never accepted.
- in_valid toggled 1/0 every cycle -> identical memory image to back-to-back input; in_ready low in WR_VAL and WR_NEXT.
- Drop start during WR_NEXT of node 2 -> IDLE next cycle; no further mem_we; done=0. Restart rewrites from BASE_ADDR.
- Assert rst_n=0 mid-WR_VAL -> mem_we, in_ready, done immediately 0, without waiting for a clock edge.
